dispensador_cambio: RTL and testbench
=====================================

// Module: dispensador_cambio
// PURPOSE
//   Consumes the 3-bit credit code a vending front end presents on product selection.
//   Drives the dispense motor when credit covers PRECIO.
//   Returns any change, or the whole credit when insufficient, as discrete coin-return pulses.
//   Sits downstream of the credit accumulator, between it and the motor/coin-hopper actuators.
// PARAMETERS
//   PRECIO        3   item price in coins; legal 1..7 (0 illegal)
//   MOTOR_CICLOS  8   cycles motor held high per dispense; >=1
//   PULSO_CICLOS  4   high width of each coin-return pulse; >=1
//   PAUSA_CICLOS  4   low gap after each coin-return pulse; >=1
// PORTS
//   clk         in   1  system clock, rising edge
//   reset_n     in   1  asynchronous, active-low reset
//   producto    in   3  credit code; nonzero in a cycle = one request (single-cycle pulse upstream)
//   listo       out  1  high in IDLE: request will be accepted
//   motor       out  1  dispense actuator drive
//   moneda_dev  out  1  coin-return hopper pulse; one pulse = one coin
//   rechazo     out  1  1-cycle pulse: request below PRECIO, full refund follows
//   hecho       out  1  1-cycle pulse: transaction complete, back to IDLE next cycle
//   descartado  out  1  1-cycle pulse: nonzero producto arrived while not IDLE (ignored)
// BEHAVIOUR
//   - All outputs registered.
//   - Reset (reset_n=0, any time, mid-transaction included): state=IDLE, all counters and
//     cambio cleared, listo=1, all other outputs 0. Motor and hopper drop on reset assertion.
//   - States: IDLE, MOTOR, PULSO, PAUSA, FIN.
//   - IDLE, producto==0: stay.
//   - IDLE, producto>=PRECIO:
//     * cambio<=producto-PRECIO (3b, no underflow possible).
//     * Next state MOTOR; motor=1 from the next cycle for exactly MOTOR_CICLOS cycles.
//   - IDLE, 0<producto<PRECIO:
//     * cambio<=producto; rechazo=1 for one cycle.
//     * Next state PULSO; motor never asserts.
//   - MOTOR, counter done: if cambio!=0 go to PULSO, else go to FIN.
//   - PULSO: moneda_dev=1 for PULSO_CICLOS cycles, then PAUSA; cambio decrements at PULSO exit.
//   - PAUSA: moneda_dev=0 for PAUSA_CICLOS cycles; then PULSO if cambio!=0, else FIN.
//   - FIN: hecho=1 for one cycle, listo=0; next state IDLE with listo=1.
//   - listo=1 only in IDLE; 0 from the cycle after acceptance until the cycle after FIN.
//   - Nonzero producto outside IDLE (includes FIN): no state change, descartado=1 next cycle.
//   - moneda_dev and motor are never high together.
//   - Exactly cambio rising edges on moneda_dev per transaction.
//   - Latency: request at edge N gives motor (or rechazo, then moneda_dev) high from cycle N+1.
//   - Dispense duration = MOTOR_CICLOS.
//   - Total change time = cambio*(PULSO_CICLOS+PAUSA_CICLOS).
//   - Counter widths sized by $clog2 of the largest cycle parameter + 1; cambio is 3 bits.
// TESTING
//   1. reset_n=0 mid-PULSO (cambio=2) -> all outputs 0, listo=1 immediately; no further pulses
//      after release.
//   2. producto=3 (exact price), defaults -> motor high 8 cycles, no moneda_dev, hecho 1 cycle
//      later, listo=1.
//   3. producto=5 -> motor 8 cycles, then 2 moneda_dev pulses (4 high/4 low), hecho, listo.
//   4. producto=2 -> rechazo 1 cycle, motor stays 0, 2 moneda_dev pulses, hecho.
//   5. producto=7 accepted, second producto=4 during MOTOR -> descartado 1 cycle, original
//      4-coin change unaffected.
//   6. PRECIO=1, MOTOR_CICLOS=1, PULSO_CICLOS=1, PAUSA_CICLOS=1, producto=7 -> motor 1 cycle,
//      6 one-cycle pulses spaced by 1.

Source files
------------

// File: rtl/dispensador_cambio_if.sv
// Bundle between the vending front end and the change dispenser:
// the credit code going in, and the actuator and status pulses coming out.
interface dispensador_cambio_if;
  logic [2:0] producto;
  logic       listo;
  logic       motor;
  logic       moneda_dev;
  logic       rechazo;
  logic       hecho;
  logic       descartado;

  // Front end side: presents the credit code, observes status and actuators.
  modport master (
    output producto,
    input  listo,
    input  motor,
    input  moneda_dev,
    input  rechazo,
    input  hecho,
    input  descartado
  );

  // Dispenser side: consumes the credit code, drives everything else.
  modport slave (
    input  producto,
    output listo,
    output motor,
    output moneda_dev,
    output rechazo,
    output hecho,
    output descartado
  );
endinterface

// File: rtl/dispensador_cambio.sv
// Change dispenser: accepts a credit code in IDLE, runs the dispense motor
// when the credit covers the price, then returns the change (or the whole
// credit on a rejected request) as one coin-return pulse per coin.
// Every output is a flop, so the actuators never see combinational glitches.
module dispensador_cambio #(
  parameter int PRECIO       = 3,
  parameter int MOTOR_CICLOS = 8,
  parameter int PULSO_CICLOS = 4,
  parameter int PAUSA_CICLOS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dispensador_cambio_if.slave  bus
);

  // Counter is sized for the longest timed phase.
  localparam int MAX_MP = (MOTOR_CICLOS > PULSO_CICLOS) ? MOTOR_CICLOS : PULSO_CICLOS;
  localparam int MAX_C  = (MAX_MP > PAUSA_CICLOS) ? MAX_MP : PAUSA_CICLOS;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [2:0]    PRECIO_3   = 3'(PRECIO);
  localparam logic [CW-1:0] MOTOR_FIN  = CW'(MOTOR_CICLOS - 1);
  localparam logic [CW-1:0] PULSO_FIN  = CW'(PULSO_CICLOS - 1);
  localparam logic [CW-1:0] PAUSA_FIN  = CW'(PAUSA_CICLOS - 1);
  localparam logic [CW-1:0] CNT_CERO   = '0;
  localparam logic [CW-1:0] CNT_UNO    = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MOTOR = 3'd1,
    PULSO = 3'd2,
    PAUSA = 3'd3,
    FIN   = 3'd4
  } estado_t;

  estado_t       state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    cambio_reg, cambio_next;

  logic listo_reg, listo_next;
  logic motor_reg, motor_next;
  logic moneda_reg, moneda_next;
  logic rechazo_reg, rechazo_next;
  logic hecho_reg, hecho_next;
  logic descartado_reg, descartado_next;

  // Next state, phase counter, pending change and the registered-output targets.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + CNT_UNO;
    cambio_next     = cambio_reg;
    rechazo_next    = 1'b0;
    descartado_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = CNT_CERO;
        if (bus.producto != 3'd0) begin
          if (bus.producto >= PRECIO_3) begin
            // Price covered: dispense first, change afterwards.
            cambio_next = bus.producto - PRECIO_3;
            state_next  = MOTOR;
          end else begin
            // Not enough credit: refund everything, motor stays off.
            cambio_next  = bus.producto;
            rechazo_next = 1'b1;
            state_next   = PULSO;
          end
        end
      end
      MOTOR: begin
        if (cnt_reg == MOTOR_FIN) begin
          cnt_next   = CNT_CERO;
          state_next = (cambio_reg != 3'd0) ? PULSO : FIN;
        end
      end
      PULSO: begin
        if (cnt_reg == PULSO_FIN) begin
          // One coin has been paid out by the end of the high phase.
          cnt_next    = CNT_CERO;
          cambio_next = cambio_reg - 3'd1;
          state_next  = PAUSA;
        end
      end
      PAUSA: begin
        if (cnt_reg == PAUSA_FIN) begin
          cnt_next   = CNT_CERO;
          state_next = (cambio_reg != 3'd0) ? PULSO : FIN;
        end
      end
      FIN: begin
        cnt_next   = CNT_CERO;
        state_next = IDLE;
      end
      default: begin
        cnt_next    = CNT_CERO;
        cambio_next = 3'd0;
        state_next  = IDLE;
      end
    endcase

    // Requests arriving while busy are dropped but flagged.
    if (state_reg != IDLE && bus.producto != 3'd0) begin
      descartado_next = 1'b1;
    end

    // Level outputs follow the state being entered, so they line up with it.
    listo_next  = (state_next == IDLE);
    motor_next  = (state_next == MOTOR);
    moneda_next = (state_next == PULSO);
    hecho_next  = (state_next == FIN);
  end

  // State, counters and all outputs; reset drops the actuators immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= CNT_CERO;
      cambio_reg     <= 3'd0;
      listo_reg      <= 1'b1;
      motor_reg      <= 1'b0;
      moneda_reg     <= 1'b0;
      rechazo_reg    <= 1'b0;
      hecho_reg      <= 1'b0;
      descartado_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cambio_reg     <= cambio_next;
      listo_reg      <= listo_next;
      motor_reg      <= motor_next;
      moneda_reg     <= moneda_next;
      rechazo_reg    <= rechazo_next;
      hecho_reg      <= hecho_next;
      descartado_reg <= descartado_next;
    end
  end

  assign bus.listo      = listo_reg;
  assign bus.motor      = motor_reg;
  assign bus.moneda_dev = moneda_reg;
  assign bus.rechazo    = rechazo_reg;
  assign bus.hecho      = hecho_reg;
  assign bus.descartado = descartado_reg;

endmodule

// File: tb/tb_dispensador_cambio.sv
// Bench for the change dispenser: one default-parameter instance and one
// instance with every parameter at its minimum. Expected per-transaction
// summaries are queued when a request is sent and checked when hecho appears.
module tb_dispensador_cambio;

  logic clk;
  logic reset_n;

  dispensador_cambio_if bus0 ();
  dispensador_cambio_if bus1 ();

  dispensador_cambio #(
    .PRECIO(3), .MOTOR_CICLOS(8), .PULSO_CICLOS(4), .PAUSA_CICLOS(4)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  dispensador_cambio #(
    .PRECIO(1), .MOTOR_CICLOS(1), .PULSO_CICLOS(1), .PAUSA_CICLOS(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance views so both instances share the same checking code.
  logic [2:0] prod [2];
  logic lst [2], mot [2], mon [2], rech [2], hec [2], desc [2];

  assign bus0.producto = prod[0];
  assign bus1.producto = prod[1];
  assign lst[0]  = bus0.listo;      assign lst[1]  = bus1.listo;
  assign mot[0]  = bus0.motor;      assign mot[1]  = bus1.motor;
  assign mon[0]  = bus0.moneda_dev; assign mon[1]  = bus1.moneda_dev;
  assign rech[0] = bus0.rechazo;    assign rech[1] = bus1.rechazo;
  assign hec[0]  = bus0.hecho;      assign hec[1]  = bus1.hecho;
  assign desc[0] = bus0.descartado; assign desc[1] = bus1.descartado;

  typedef struct {
    int dut;
    int motor;
    int rises;
    int coin_hi;
    int busy;
    int rech;
    int desc;
    int overlap;
  } txn_t;

  txn_t sb_q[$];
  txn_t acc [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: accumulate what each instance does, compare on every hecho.
  initial begin
    logic mon_prev [2];
    txn_t e;
    mon_prev[0] = 1'b0;
    mon_prev[1] = 1'b0;
    for (int k = 0; k < 2; k++) acc[k] = '{k, 0, 0, 0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) begin
          acc[k] = '{k, 0, 0, 0, 0, 0, 0, 0};
        end else begin
          if (mot[k]) acc[k].motor++;
          if (mon[k]) acc[k].coin_hi++;
          if (mon[k] && !mon_prev[k]) acc[k].rises++;
          if (mot[k] && mon[k]) acc[k].overlap++;
          if (rech[k]) acc[k].rech++;
          if (desc[k]) acc[k].desc++;
          if (!lst[k]) acc[k].busy++;
          if (hec[k]) begin
            if (sb_q.size() == 0) begin
              check($sformatf("spurious_hecho_dut%0d", k), sb_q.size(), 1);
            end else begin
              e = sb_q.pop_front();
              check("txn_dut",      k,                e.dut);
              check("txn_motor",    acc[k].motor,     e.motor);
              check("txn_pulses",   acc[k].rises,     e.rises);
              check("txn_coin_hi",  acc[k].coin_hi,   e.coin_hi);
              check("txn_busy",     acc[k].busy,      e.busy);
              check("txn_rechazo",  acc[k].rech,      e.rech);
              check("txn_descart",  acc[k].desc,      e.desc);
              check("txn_overlap",  acc[k].overlap,   e.overlap);
              check("txn_listo_fin", int'(lst[k]),    0);
              $display("[TB] dut%0d txn: motor=%0d pulses=%0d busy=%0d rechazo=%0d descartado=%0d",
                       k, acc[k].motor, acc[k].rises, acc[k].busy, acc[k].rech, acc[k].desc);
            end
            acc[k] = '{k, 0, 0, 0, 0, 0, 0, 0};
          end
        end
        mon_prev[k] = mon[k];
      end
    end
  end

  // Send one request; optionally queue its expected summary and check first-cycle latency.
  task automatic send(input int k, input logic [2:0] val, input int desc_exp, input bit push);
    txn_t e;
    int price, m, p, g, c;
    bit ok;
    price = (k == 0) ? 3 : 1;
    m     = (k == 0) ? 8 : 1;
    p     = (k == 0) ? 4 : 1;
    g     = (k == 0) ? 4 : 1;
    ok    = (int'(val) >= price);
    c     = ok ? int'(val) - price : int'(val);
    e.dut     = k;
    e.motor   = ok ? m : 0;
    e.rises   = c;
    e.coin_hi = c * p;
    e.busy    = e.motor + c * (p + g) + 1;
    e.rech    = ok ? 0 : 1;
    e.desc    = desc_exp;
    e.overlap = 0;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    prod[k] = val;
    @(negedge clk);
    prod[k] = 3'd0;
    check("lat_motor",   int'(mot[k]),  ok ? 1 : 0);
    check("lat_rechazo", int'(rech[k]), ok ? 0 : 1);
    check("lat_moneda",  int'(mon[k]),  ok ? 0 : 1);
    check("lat_listo",   int'(lst[k]),  0);
  endtask

  // Bounded wait for the queued transaction to be consumed, then listo must be back.
  task automatic wait_done(input int k);
    int i;
    for (i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check("timeout_hecho", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clk);
    check("listo_after", int'(lst[k]), 1);
  endtask

  initial begin
    int cnt;
    int i;
    prod[0] = 3'd0;
    prod[1] = 3'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < 2; k++) begin
      check("rst_listo",  int'(lst[k]),  1);
      check("rst_motor",  int'(mot[k]),  0);
      check("rst_moneda", int'(mon[k]),  0);
      check("rst_hecho",  int'(hec[k]),  0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exact price, change above price, rejected credit
    send(0, 3'd3, 0, 1'b1); wait_done(0);
    send(0, 3'd5, 0, 1'b1); wait_done(0);
    send(0, 3'd2, 0, 1'b1); wait_done(0);

    // Second request during MOTOR is dropped and flagged
    send(0, 3'd7, 1, 1'b1);
    prod[0] = 3'd4;
    @(negedge clk);
    prod[0] = 3'd0;
    check("desc_pulse", int'(desc[0]), 1);
    check("desc_motor", int'(mot[0]),  1);
    @(negedge clk);
    check("desc_one_cycle", int'(desc[0]), 0);
    wait_done(0);

    // Minimum timing instance
    send(1, 3'd7, 0, 1'b1); wait_done(1);

    // Reset in the middle of a coin pulse
    send(0, 3'd5, 0, 1'b0);
    for (i = 0; i < 100 && !mon[0]; i++) @(negedge clk);
    check("reach_pulso", int'(mon[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_moneda", int'(mon[0]), 0);
    check("arst_motor",  int'(mot[0]), 0);
    check("arst_listo",  int'(lst[0]), 1);
    check("arst_hecho",  int'(hec[0]), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (mon[0]) cnt++;
    end
    check("no_pulse_after_rst", cnt, 0);
    check("listo_after_rst", int'(lst[0]), 1);

    // Normal operation resumes after reset
    send(0, 3'd6, 0, 1'b1); wait_done(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
